// File: rtl/weight_mem_loader_pkg.sv
// rtl/weight_mem_loader_pkg.sv - shared sizes, port-mode encodings and FSM states for the weight loader
//
// Purpose: one place for the weight-memory geometry and the loader state
// encoding, so the loader and its byte packer agree on the same values.
// Ports: none (package).
package weight_mem_loader_pkg;

   localparam int N_DIM_ARRAY       = 4;
   localparam int WEIGHT_DATA_WIDTH = 8;
   localparam int ADDR_W            = 14;

   localparam logic MODE_FC  = 1'b0;
   localparam logic MODE_CNN = 1'b1;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_LOAD  = 2'd1,
      ST_DRAIN = 2'd2
   } state_t;

endpackage

// File: rtl/weight_byte_packer.sv
// rtl/weight_byte_packer.sv - packs a byte stream into weight words, first byte in the LSBs
//
// Purpose: shift register plus byte counter that assembles N_DIM_ARRAY bytes
// into one word. word_done_o/word_data_o are combinational and describe the
// byte being accepted this cycle; the loader registers them.
// Ports:
//   clk, reset          clock, asynchronous active-low reset
//   clear_i             drop any partial word and restart at byte 0
//   byte_valid_i        a byte is accepted this cycle
//   byte_data_i         the accepted byte
//   word_done_o         this byte completes a word
//   word_data_o         the completed word (valid with word_done_o)
module weight_byte_packer #(
   parameter int N_DIM_ARRAY       = weight_mem_loader_pkg::N_DIM_ARRAY,
   parameter int WEIGHT_DATA_WIDTH = weight_mem_loader_pkg::WEIGHT_DATA_WIDTH
) (
   input  logic                                      clk,
   input  logic                                      reset,
   input  logic                                      clear_i,
   input  logic                                      byte_valid_i,
   input  logic [WEIGHT_DATA_WIDTH-1:0]              byte_data_i,
   output logic                                      word_done_o,
   output logic [N_DIM_ARRAY*WEIGHT_DATA_WIDTH-1:0]  word_data_o
);

   import weight_mem_loader_pkg::*;

   // Only N-1 bytes are held; the final byte goes straight to the output.
   localparam int HOLD_W = (N_DIM_ARRAY - 1) * WEIGHT_DATA_WIDTH;
   localparam int CNT_W  = (N_DIM_ARRAY > 1) ? $clog2(N_DIM_ARRAY) : 1;
   localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(N_DIM_ARRAY - 1);

   logic [HOLD_W-1:0] shift_q, shift_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;

   // New bytes enter at the top, so earlier bytes migrate toward the LSBs.
   assign shift_d     = {byte_data_i, shift_q[HOLD_W-1:WEIGHT_DATA_WIDTH]};
   assign word_data_o = {byte_data_i, shift_q};
   assign word_done_o = byte_valid_i && !clear_i && (cnt_q == LAST_IDX);

   always_comb begin
      cnt_d = cnt_q;
      if (clear_i) begin
         cnt_d = '0;
      end else if (byte_valid_i) begin
         cnt_d = (cnt_q == LAST_IDX) ? '0 : cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         shift_q <= '0;
         cnt_q   <= '0;
      end else begin
         cnt_q <= cnt_d;
         if (clear_i) begin
            shift_q <= '0;
         end else if (byte_valid_i) begin
            shift_q <= shift_d;
         end
      end
   end

endmodule

// File: rtl/weight_mem_loader.sv
// rtl/weight_mem_loader.sv - streams weight bytes into the FC or CNN weight memory write port
//
// Purpose: accepts a load request (mode, base address, word count), range
// checks it, packs incoming bytes into words and writes them to consecutive
// addresses on the selected port.
// Ports:
//   clk, reset                  clock, asynchronous active-low reset
//   start, abort                load request / cancel
//   cfg_mode                    0 = FC port, 1 = CNN port
//   cfg_base_addr, cfg_num_words  first word address, words to load
//   in_valid, in_data, in_ready   byte stream
//   wr_*_ext_fc_w               FC weight-memory write port
//   wr_*_ext_cnn_w              CNN weight-memory write port
//   busy, done, error           status; done/error are one-cycle pulses
module weight_mem_loader #(
   parameter int N_DIM_ARRAY       = weight_mem_loader_pkg::N_DIM_ARRAY,
   parameter int WEIGHT_DATA_WIDTH = weight_mem_loader_pkg::WEIGHT_DATA_WIDTH,
   parameter int ADDR_W            = weight_mem_loader_pkg::ADDR_W
) (
   input  logic                                     clk,
   input  logic                                     reset,
   input  logic                                     start,
   input  logic                                     abort,
   input  logic                                     cfg_mode,
   input  logic [ADDR_W-1:0]                        cfg_base_addr,
   input  logic [ADDR_W:0]                          cfg_num_words,
   input  logic                                     in_valid,
   input  logic [WEIGHT_DATA_WIDTH-1:0]             in_data,
   output logic                                     in_ready,
   output logic                                     wr_en_ext_fc_w,
   output logic [ADDR_W-1:0]                        wr_addr_ext_fc_w,
   output logic [N_DIM_ARRAY*WEIGHT_DATA_WIDTH-1:0] wr_data_ext_fc_w,
   output logic                                     wr_en_ext_cnn_w,
   output logic [ADDR_W-1:0]                        wr_addr_ext_cnn_w,
   output logic [N_DIM_ARRAY*WEIGHT_DATA_WIDTH-1:0] wr_data_ext_cnn_w,
   output logic                                     busy,
   output logic                                     done,
   output logic                                     error
);

   import weight_mem_loader_pkg::*;

   localparam int WORD_W = N_DIM_ARRAY * WEIGHT_DATA_WIDTH;
   // One extra bit over the count width so base+count can never wrap.
   localparam int SUM_W = ADDR_W + 2;
   localparam logic [SUM_W-1:0] ADDR_SPAN = SUM_W'(1) << ADDR_W;

   state_t              state_q;
   logic                mode_q;
   logic [ADDR_W-1:0]   base_q;
   logic [ADDR_W:0]     num_q;
   logic [ADDR_W:0]     word_idx_q;
   logic                in_ready_q;
   logic                busy_q;
   logic                done_q;
   logic                error_q;
   logic                fc_en_q, cnn_en_q;
   logic [ADDR_W-1:0]   fc_addr_q, cnn_addr_q;
   logic [WORD_W-1:0]   fc_data_q, cnn_data_q;

   logic                pk_clear;
   logic                pk_valid;
   logic                word_done;
   logic [WORD_W-1:0]   word_data;
   logic [SUM_W-1:0]    end_addr;
   logic                last_word;
   logic [ADDR_W-1:0]   wr_addr;

   // The packer restarts whenever we are not actively loading, so a
   // partial word never survives an abort or a finished transfer.
   assign pk_clear  = abort || (state_q != ST_LOAD);
   assign pk_valid  = in_valid && in_ready_q;

   assign end_addr  = SUM_W'(cfg_base_addr) + SUM_W'(cfg_num_words);
   assign last_word = (word_idx_q == num_q - (ADDR_W+1)'(1));
   assign wr_addr   = base_q + word_idx_q[ADDR_W-1:0];

   weight_byte_packer #(
      .N_DIM_ARRAY       (N_DIM_ARRAY),
      .WEIGHT_DATA_WIDTH (WEIGHT_DATA_WIDTH)
   ) u_packer (
      .clk          (clk),
      .reset        (reset),
      .clear_i      (pk_clear),
      .byte_valid_i (pk_valid),
      .byte_data_i  (in_data),
      .word_done_o  (word_done),
      .word_data_o  (word_data)
   );

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= ST_IDLE;
         mode_q     <= MODE_FC;
         base_q     <= '0;
         num_q      <= '0;
         word_idx_q <= '0;
         in_ready_q <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         error_q    <= 1'b0;
         fc_en_q    <= 1'b0;
         fc_addr_q  <= '0;
         fc_data_q  <= '0;
         cnn_en_q   <= 1'b0;
         cnn_addr_q <= '0;
         cnn_data_q <= '0;
      end else begin
         // Pulses and write strobes last one cycle; address/data return to zero with them.
         done_q     <= 1'b0;
         error_q    <= 1'b0;
         fc_en_q    <= 1'b0;
         fc_addr_q  <= '0;
         fc_data_q  <= '0;
         cnn_en_q   <= 1'b0;
         cnn_addr_q <= '0;
         cnn_data_q <= '0;

         case (state_q)
            ST_IDLE: begin
               // abort has no meaning here, so start always wins.
               if (start) begin
                  if (cfg_num_words == '0) begin
                     done_q <= 1'b1;
                  end else if (end_addr > ADDR_SPAN) begin
                     error_q <= 1'b1;
                  end else begin
                     state_q    <= ST_LOAD;
                     in_ready_q <= 1'b1;
                     busy_q     <= 1'b1;
                     mode_q     <= cfg_mode;
                     base_q     <= cfg_base_addr;
                     num_q      <= cfg_num_words;
                     word_idx_q <= '0;
                  end
               end
            end

            ST_LOAD: begin
               if (abort) begin
                  state_q    <= ST_IDLE;
                  in_ready_q <= 1'b0;
                  busy_q     <= 1'b0;
               end else if (word_done) begin
                  if (mode_q == MODE_CNN) begin
                     cnn_en_q   <= 1'b1;
                     cnn_addr_q <= wr_addr;
                     cnn_data_q <= word_data;
                  end else begin
                     fc_en_q    <= 1'b1;
                     fc_addr_q  <= wr_addr;
                     fc_data_q  <= word_data;
                  end
                  word_idx_q <= word_idx_q + (ADDR_W+1)'(1);
                  if (last_word) begin
                     state_q    <= ST_DRAIN;
                     in_ready_q <= 1'b0;
                  end
               end
            end

            ST_DRAIN: begin
               // The final strobe is on the port during this cycle.
               state_q <= ST_IDLE;
               busy_q  <= 1'b0;
               done_q  <= !abort;
            end

            default: begin
               state_q    <= ST_IDLE;
               in_ready_q <= 1'b0;
               busy_q     <= 1'b0;
            end
         endcase
      end
   end

   assign in_ready          = in_ready_q;
   assign busy              = busy_q;
   assign done              = done_q;
   assign error             = error_q;
   assign wr_en_ext_fc_w    = fc_en_q;
   assign wr_addr_ext_fc_w  = fc_addr_q;
   assign wr_data_ext_fc_w  = fc_data_q;
   assign wr_en_ext_cnn_w   = cnn_en_q;
   assign wr_addr_ext_cnn_w = cnn_addr_q;
   assign wr_data_ext_cnn_w = cnn_data_q;

endmodule

// File: tb/tb_weight_mem_loader.sv
// tb/tb_weight_mem_loader.sv - directed self-checking bench for weight_mem_loader
module tb_weight_mem_loader;

   logic        clk = 1'b0;
   logic        reset;
   logic        start;
   logic        abort;
   logic        cfg_mode;
   logic [13:0] cfg_base_addr;
   logic [14:0] cfg_num_words;
   logic        in_valid;
   logic [7:0]  in_data;
   logic        in_ready;
   logic        wr_en_ext_fc_w;
   logic [13:0] wr_addr_ext_fc_w;
   logic [31:0] wr_data_ext_fc_w;
   logic        wr_en_ext_cnn_w;
   logic [13:0] wr_addr_ext_cnn_w;
   logic [31:0] wr_data_ext_cnn_w;
   logic        busy;
   logic        done;
   logic        error;

   weight_mem_loader dut (
      .clk               (clk),
      .reset             (reset),
      .start             (start),
      .abort             (abort),
      .cfg_mode          (cfg_mode),
      .cfg_base_addr     (cfg_base_addr),
      .cfg_num_words     (cfg_num_words),
      .in_valid          (in_valid),
      .in_data           (in_data),
      .in_ready          (in_ready),
      .wr_en_ext_fc_w    (wr_en_ext_fc_w),
      .wr_addr_ext_fc_w  (wr_addr_ext_fc_w),
      .wr_data_ext_fc_w  (wr_data_ext_fc_w),
      .wr_en_ext_cnn_w   (wr_en_ext_cnn_w),
      .wr_addr_ext_cnn_w (wr_addr_ext_cnn_w),
      .wr_data_ext_cnn_w (wr_data_ext_cnn_w),
      .busy              (busy),
      .done              (done),
      .error             (error)
   );

   always #5 clk = ~clk;

   int n_vec = 0;
   int n_bad = 0;

   int n_done = 0;
   int n_err  = 0;
   int n_busy = 0;
   int n_zv   = 0;
   logic        w_port[$];
   logic [13:0] w_addr[$];
   logic [31:0] w_data[$];

   // Write log and port-idle invariant, sampled mid-cycle.
   always @(negedge clk) begin
      if (wr_en_ext_fc_w) begin
         w_port.push_back(1'b0);
         w_addr.push_back(wr_addr_ext_fc_w);
         w_data.push_back(wr_data_ext_fc_w);
      end
      if (wr_en_ext_cnn_w) begin
         w_port.push_back(1'b1);
         w_addr.push_back(wr_addr_ext_cnn_w);
         w_data.push_back(wr_data_ext_cnn_w);
      end
      n_zv <= n_zv
            + ((!wr_en_ext_fc_w  && (wr_addr_ext_fc_w  != '0 || wr_data_ext_fc_w  != '0)) ? 1 : 0)
            + ((!wr_en_ext_cnn_w && (wr_addr_ext_cnn_w != '0 || wr_data_ext_cnn_w != '0)) ? 1 : 0);
      n_done <= n_done + (done  ? 1 : 0);
      n_err  <= n_err  + (error ? 1 : 0);
      n_busy <= n_busy + (busy  ? 1 : 0);
   end

   task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   function automatic logic [127:0] outs();
      logic [127:0] v;
      v = '0;
      v[97:0] = {in_ready, busy, done, error,
                 wr_en_ext_fc_w, wr_addr_ext_fc_w, wr_data_ext_fc_w,
                 wr_en_ext_cnn_w, wr_addr_ext_cnn_w, wr_data_ext_cnn_w};
      return v;
   endfunction

   function automatic logic [127:0] fc_port();
      return 128'({wr_en_ext_fc_w, wr_addr_ext_fc_w, wr_data_ext_fc_w});
   endfunction

   function automatic logic [127:0] cnn_port();
      return 128'({wr_en_ext_cnn_w, wr_addr_ext_cnn_w, wr_data_ext_cnn_w});
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_start(input logic m, input logic [13:0] b, input logic [14:0] n);
      cfg_mode      = m;
      cfg_base_addr = b;
      cfg_num_words = n;
      start         = 1'b1;
      step();
      start         = 1'b0;
   endtask

   // Presents one byte and returns just after the edge that accepted it.
   task automatic send_byte(input logic [7:0] b);
      int g;
      g = 0;
      in_valid = 1'b1;
      in_data  = b;
      while (!in_ready && g < 20) begin
         step();
         g++;
      end
      if (g >= 20) chk("ready_wait", 128'(in_ready), 128'(1));
      step();
      in_valid = 1'b0;
   endtask

   int w0, d0, e0, b0;

   initial begin
      reset = 1'b0; start = 1'b0; abort = 1'b0; cfg_mode = 1'b0;
      cfg_base_addr = '0; cfg_num_words = '0; in_valid = 1'b0; in_data = '0;
      repeat (3) step();
      chk("reset_outs", outs(), 128'(0));
      reset = 1'b1;
      step();
      chk("idle_outs", outs(), 128'(0));

      // FC load, two words back-to-back
      w0 = w_addr.size(); d0 = n_done;
      do_start(1'b0, 14'h0010, 15'd2);
      chk("fc_start", 128'({busy, in_ready}), 128'(2'b11));
      for (int i = 0; i < 4; i++) send_byte(8'(i + 1));
      chk("fc_word0", fc_port(), 128'({1'b1, 14'h0010, 32'h04030201}));
      chk("fc_word0_cnn", cnn_port(), 128'(0));
      for (int i = 4; i < 8; i++) send_byte(8'(i + 1));
      chk("fc_word1", fc_port(), 128'({1'b1, 14'h0011, 32'h08070605}));
      chk("fc_drain", 128'({busy, in_ready, done}), 128'(3'b100));
      step();
      chk("fc_done", 128'({busy, done, wr_en_ext_fc_w}), 128'(3'b010));
      step();
      chk("fc_done_pulse", 128'(done), 128'(0));
      chk("fc_nwr", 128'(w_addr.size() - w0), 128'(2));
      chk("fc_ndone", 128'(n_done - d0), 128'(1));

      // CNN load with in_valid gaps
      w0 = w_addr.size();
      do_start(1'b1, 14'h2000, 15'd1);
      send_byte(8'hAA); step();
      chk("cnn_gap", 128'({in_ready, wr_en_ext_cnn_w}), 128'(2'b10));
      send_byte(8'hBB); step();
      send_byte(8'hCC); step();
      send_byte(8'hDD);
      chk("cnn_word", cnn_port(), 128'({1'b1, 14'h2000, 32'hDDCCBBAA}));
      chk("cnn_ready_low", 128'(in_ready), 128'(0));
      chk("cnn_fc_quiet", fc_port(), 128'(0));
      step();
      chk("cnn_done", 128'(done), 128'(1));
      chk("cnn_nwr", 128'(w_addr.size() - w0), 128'(1));

      // Range edge: last word of memory, then one past it
      do_start(1'b0, 14'h3FFF, 15'd1);
      send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h44);
      chk("edge_word", fc_port(), 128'({1'b1, 14'h3FFF, 32'h44332211}));
      step(); step();
      w0 = w_addr.size(); e0 = n_err; b0 = n_busy;
      do_start(1'b0, 14'h3FFF, 15'd2);
      chk("range_err", 128'({error, busy, in_ready}), 128'(3'b100));
      step();
      chk("range_err_pulse", 128'(error), 128'(0));
      chk("range_nwr", 128'(w_addr.size() - w0), 128'(0));
      chk("range_nerr", 128'(n_err - e0), 128'(1));
      chk("range_nbusy", 128'(n_busy - b0), 128'(0));

      // Zero-length request
      w0 = w_addr.size(); d0 = n_done;
      do_start(1'b1, 14'h0100, 15'd0);
      chk("zero_done", 128'({done, busy}), 128'(2'b10));
      step();
      chk("zero_ndone", 128'(n_done - d0), 128'(1));
      chk("zero_nwr", 128'(w_addr.size() - w0), 128'(0));

      // Start while busy is ignored
      w0 = w_addr.size();
      do_start(1'b0, 14'h0040, 15'd2);
      send_byte(8'h5A); send_byte(8'h5B);
      cfg_mode = 1'b1; cfg_base_addr = 14'h0300; cfg_num_words = 15'd5;
      start = 1'b1; step(); start = 1'b0;
      for (int i = 0; i < 6; i++) send_byte(8'(8'h5C + i));
      step(); step();
      chk("busy_nwr", 128'(w_addr.size() - w0), 128'(2));
      if (w_addr.size() - w0 >= 2) begin
         chk("busy_w0", 128'({w_port[w0], w_addr[w0], w_data[w0]}), 128'({1'b0, 14'h0040, 32'h5D5C5B5A}));
         chk("busy_w1", 128'({w_port[w0+1], w_addr[w0+1], w_data[w0+1]}), 128'({1'b0, 14'h0041, 32'h61605F5E}));
      end

      // start and abort together in IDLE: start wins; abort then cancels
      cfg_mode = 1'b1; cfg_base_addr = 14'h0200; cfg_num_words = 15'd1;
      start = 1'b1; abort = 1'b1; step(); start = 1'b0; abort = 1'b0;
      chk("start_wins", 128'(busy), 128'(1));
      abort = 1'b1; step(); abort = 1'b0;
      chk("abort_idle", 128'(busy), 128'(0));

      // Abort after 6 of 8 bytes
      w0 = w_addr.size(); d0 = n_done;
      do_start(1'b0, 14'h0080, 15'd2);
      for (int i = 0; i < 6; i++) send_byte(8'(8'h10 + i));
      abort = 1'b1; step(); abort = 1'b0;
      chk("abort_state", 128'({busy, in_ready, done, wr_en_ext_fc_w}), 128'(0));
      step(); step();
      chk("abort_nwr", 128'(w_addr.size() - w0), 128'(1));
      if (w_addr.size() - w0 >= 1)
         chk("abort_w0", 128'({w_addr[w0], w_data[w0]}), 128'({14'h0080, 32'h13121110}));
      chk("abort_ndone", 128'(n_done - d0), 128'(0));
      do_start(1'b0, 14'h0000, 15'd1);
      send_byte(8'hA1); send_byte(8'hA2); send_byte(8'hA3); send_byte(8'hA4);
      chk("post_abort", fc_port(), 128'({1'b1, 14'h0000, 32'hA4A3A2A1}));
      step(); step();

      // Asynchronous reset mid-load
      w0 = w_addr.size();
      do_start(1'b1, 14'h0055, 15'd2);
      send_byte(8'h01); send_byte(8'h02);
      reset = 1'b0;
      #1;
      chk("async_reset", outs(), 128'(0));
      step();
      reset = 1'b1;
      in_valid = 1'b1; in_data = 8'h77;
      repeat (10) step();
      in_valid = 1'b0;
      chk("post_reset_ready", 128'({in_ready, busy}), 128'(0));
      chk("post_reset_nwr", 128'(w_addr.size() - w0), 128'(0));

      chk("idle_port_zero", 128'(n_zv), 128'(0));

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1, "watchdog expired");
   end

endmodule
